nand_gate_sweeper: RTL and testbench
====================================

NAND_GATE_SWEEPER -- requirements
Module: nand_gate_sweeper

Interface
REQ-001 Parameter SETTLE, default 1, meaning cycles a vector is held before the output is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a sweep; ignored while busy=1.
REQ-005 dut_out  input  1  gate output from the downstream 8-function NAND-implemented gate block.
REQ-006 sel_o  output  3  function select driven to the gate block.
REQ-007 a_o  output  1  operand a driven to the gate block.
REQ-008 b_o  output  1  operand b driven to the gate block.
REQ-009 busy  output  1  high from the cycle after start is accepted until the DONE cycle inclusive.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 pass  output  1  high when the last completed sweep had zero mismatches; held until the next start.
REQ-012 err_cnt  output  6  mismatch count of the current/last sweep, range 0..32.
REQ-013 first_err_vec  output  5  {sel,a,b} of the first mismatch; valid only when err_cnt!=0.

Function
REQ-014 Vector index vec[4:0] SHALL map as {sel_o,a_o,b_o}=vec, swept 0..31 in ascending order.
REQ-015 Expected output by sel: 000 NAND, 001 AND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT a, 111 NOT a.
REQ-016 FSM states: IDLE, APPLY, CHECK, DONE.
REQ-017 IDLE: outputs sel_o/a_o/b_o=0; start=1 -> APPLY with vec=0, err_cnt=0, first_err_vec=0, pass=0, settle counter=0.
REQ-018 APPLY: vec held on outputs; settle counter increments each cycle; after SETTLE cycles in APPLY -> CHECK.
REQ-019 CHECK (one cycle): dut_out compared to expected for vec; mismatch increments err_cnt and, if err_cnt was 0, loads first_err_vec=vec.
REQ-020 CHECK: vec!=31 -> vec+1, settle counter=0, APPLY; vec==31 -> DONE (no wrap to 0).
REQ-021 DONE (one cycle): done=1, pass=(err_cnt==0), then IDLE; outputs hold vector 31 during DONE.
REQ-022 Sweep length SHALL be exactly 32*(SETTLE+1)+1 cycles from the cycle after start to the DONE cycle inclusive.
REQ-023 start asserted in APPLY, CHECK or DONE SHALL have no effect; start in the cycle after DONE (IDLE) begins a new sweep.
REQ-024 err_cnt SHALL reach 32 without overflow (6-bit width); no saturation logic.
REQ-025 All outputs registered; dut_out sampled only in CHECK.

Reset
REQ-026 rst_n=0 at any time, including mid-sweep, SHALL immediately force IDLE, vec=0, sel_o=0, a_o=0, b_o=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vec=0.
REQ-027 First start accepted no earlier than the first rising clk edge after rst_n deasserts.

Structure
REQ-028 Shared package nand_sweep_pkg SHALL hold sel function encodings (8 constants) and FSM state encodings.
REQ-029 Expected-value function SHALL be a combinational sub-module gate_ref_model (sel,a,b -> exp).

Verification
REQ-030 Correct gate model on dut_out, SETTLE=1, start pulse -> done after 65 cycles, pass=1, err_cnt=0.
REQ-031 dut_out stuck at 0 -> err_cnt=16 (expected-one count over 32 vectors), first_err_vec=5'b00000 (NAND 0,0), pass=0.
REQ-032 Model with sel=100 inverted (XNOR instead of XOR) -> err_cnt=4, first_err_vec=5'b10000, pass=0.
REQ-033 SETTLE=3, correct model -> done 129 cycles after start; start re-pulsed at cycle 50 ignored.
REQ-034 rst_n low at vec=12 mid-sweep -> all outputs 0 asynchronously, busy=0; new start restarts from vec=0.
REQ-035 Back-to-back: start in cycle after done -> second sweep completes, err_cnt/first_err_vec from first sweep cleared at start.

Source files
------------

// File: rtl/nand_sweep_pkg.sv
// Shared encodings for the NAND gate-block sweeper: function selects and FSM states.
package nand_sweep_pkg;

  localparam logic [2:0] SEL_NAND     = 3'd0;
  localparam logic [2:0] SEL_AND      = 3'd1;
  localparam logic [2:0] SEL_OR       = 3'd2;
  localparam logic [2:0] SEL_NOR      = 3'd3;
  localparam logic [2:0] SEL_XOR      = 3'd4;
  localparam logic [2:0] SEL_XNOR     = 3'd5;
  localparam logic [2:0] SEL_NOTA     = 3'd6;
  localparam logic [2:0] SEL_NOTA_ALT = 3'd7;

  localparam logic [4:0] LAST_VEC = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the 8-function gate block.
module gate_ref_model
  import nand_sweep_pkg::*;
(
  input  logic [2:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       exp
);

  always_comb begin
    exp = 1'b0;
    unique case (sel)
      SEL_NAND:     exp = ~(a & b);
      SEL_AND:      exp = a & b;
      SEL_OR:       exp = a | b;
      SEL_NOR:      exp = ~(a | b);
      SEL_XOR:      exp = a ^ b;
      SEL_XNOR:     exp = ~(a ^ b);
      SEL_NOTA:     exp = ~a;
      SEL_NOTA_ALT: exp = ~a;
      default:      exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/nand_gate_sweeper.sv
// Exhaustively sweeps all 32 {sel,a,b} vectors into a gate block and counts mismatches.
module nand_gate_sweeper
  import nand_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic [2:0] sel_o,
  output logic       a_o,
  output logic       b_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_cnt,
  output logic [4:0] first_err_vec
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state, state_d;
  logic [4:0] vec, vec_d;
  logic [3:0] cnt, cnt_d;
  logic [5:0] err_d;
  logic [4:0] fev_d;
  logic       pass_d, busy_d, done_d;
  logic       exp_bit;

  gate_ref_model u_ref (
    .sel (vec[4:2]),
    .a   (vec[1]),
    .b   (vec[0]),
    .exp (exp_bit)
  );

  // vec is cleared on leaving DONE, so the driven vector is zero whenever idle
  assign {sel_o, a_o, b_o} = vec;

  always_comb begin
    state_d = state;
    vec_d   = vec;
    cnt_d   = cnt;
    err_d   = err_cnt;
    fev_d   = first_err_vec;
    pass_d  = pass;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_APPLY;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fev_d   = '0;
          pass_d  = 1'b0;
        end
      end
      ST_APPLY: begin
        cnt_d = cnt + 4'd1;
        if (cnt == SETTLE_LAST) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (dut_out != exp_bit) begin
          err_d = err_cnt + 6'd1;
          if (err_cnt == '0) fev_d = vec;
        end
        if (vec == LAST_VEC) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_APPLY;
          vec_d   = vec + 5'd1;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        vec_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      vec           <= '0;
      cnt           <= '0;
      err_cnt       <= '0;
      first_err_vec <= '0;
      pass          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_d;
      vec           <= vec_d;
      cnt           <= cnt_d;
      err_cnt       <= err_d;
      first_err_vec <= fev_d;
      pass          <= pass_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

endmodule

// File: tb/tb_nand_gate_sweeper.sv
// Bench: two sweepers (SETTLE=1 and 3) driving a gate block with injectable per-vector faults.
module tb_nand_gate_sweeper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start [2];
  logic        dout  [2];
  logic [2:0]  sel   [2];
  logic        a     [2];
  logic        b     [2];
  logic        busy  [2];
  logic        done  [2];
  logic        pass  [2];
  logic [5:0]  err   [2];
  logic [4:0]  fev   [2];
  logic [31:0] mask  [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic ref_exp(input logic [4:0] v);
    logic x, y;
    x = v[1];
    y = v[0];
    case (v[4:2])
      3'd0: return ~(x & y);
      3'd1: return x & y;
      3'd2: return x | y;
      3'd3: return ~(x | y);
      3'd4: return x ^ y;
      3'd5: return ~(x ^ y);
      default: return ~x;
    endcase
  endfunction

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int len_of(input int i);
    return 32 * (settle_of(i) + 1) + 1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    nand_gate_sweeper #(.SETTLE(g == 0 ? 1 : 3)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start[g]),
      .dut_out       (dout[g]),
      .sel_o         (sel[g]),
      .a_o           (a[g]),
      .b_o           (b[g]),
      .busy          (busy[g]),
      .done          (done[g]),
      .pass          (pass[g]),
      .err_cnt       (err[g]),
      .first_err_vec (fev[g])
    );
    // Gate block: correct function, inverted on vectors flagged in mask
    assign dout[g] = ref_exp({sel[g], a[g], b[g]}) ^ mask[g][{sel[g], a[g], b[g]}];
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Model: cycle position t within a sweep (1 = cycle after start accepted)
  bit          started [2];
  int          t       [2];
  logic [31:0] smask   [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        started[i] <= 1'b0;
        t[i]       <= 0;
        smask[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if ((!started[i] || t[i] > len_of(i)) && start[i]) begin
          started[i] <= 1'b1;
          t[i]       <= 1;
          smask[i]   <= mask[i];
        end else if (started[i] && t[i] <= len_of(i)) begin
          t[i] <= t[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int s, ln, n, f, ev;
      bit have, eb, ed, ep;
      s = settle_of(i); ln = len_of(i);
      n = 0; f = 0; ev = 0; have = 0; eb = 0; ed = 0; ep = 0;
      if (started[i]) begin
        for (int v = 0; v < 32; v++) begin
          if (smask[i][v] && (v + 1) * (s + 1) < t[i]) begin
            n++;
            if (!have) f = v;
            have = 1;
          end
        end
        eb = (t[i] <= ln);
        ed = (t[i] == ln);
        ep = (t[i] >= ln) && (n == 0);
        ev = (t[i] < ln) ? (t[i] - 1) / (s + 1) : (t[i] == ln) ? 31 : 0;
      end
      chk($sformatf("vec%0d", i), int'({sel[i], a[i], b[i]}), ev);
      chk($sformatf("busy%0d", i), int'(busy[i]), int'(eb));
      chk($sformatf("done%0d", i), int'(done[i]), int'(ed));
      chk($sformatf("pass%0d", i), int'(pass[i]), int'(ep));
      chk($sformatf("err_cnt%0d", i), int'(err[i]), n);
      chk($sformatf("first_err%0d", i), int'(fev[i]), f);
    end
  end

  task automatic run_sweep(input int i, input logic [31:0] m, input int repulse, output int n);
    @(negedge clk);
    mask[i] = m;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    n = 1;
    while (!done[i] && n < 400) begin
      @(negedge clk);
      n++;
      start[i] = (n == repulse);
    end
    start[i] = 1'b0;
    if (!done[i]) chk($sformatf("done_timeout%0d", i), 0, 1);
  endtask

  initial begin
    int n;
    logic [31:0] m;
    start[0] = 1'b0; start[1] = 1'b0;
    mask[0] = '0;    mask[1] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_err", int'(err[0]), 0);

    // Correct gate block
    run_sweep(0, 32'h0, 0, n);
    chk("len_settle1", n, 65);
    chk("good_pass", int'(pass[0]), 1);
    chk("good_err", int'(err[0]), 0);

    // dut_out stuck at 0: mismatches exactly where expected output is 1
    for (int v = 0; v < 32; v++) m[v] = ref_exp(5'(v));
    chk("model_ones", $countones(m), 16);
    run_sweep(0, m, 0, n);
    chk("stuck0_err", int'(err[0]), 16);
    chk("stuck0_fev", int'(fev[0]), 0);
    chk("stuck0_pass", int'(pass[0]), 0);

    // Back-to-back: XOR slot behaves as XNOR
    run_sweep(0, 32'h000F_0000, 0, n);
    chk("b2b_len", n, 65);
    chk("xnor_err", int'(err[0]), 4);
    chk("xnor_fev", int'(fev[0]), 16);
    chk("xnor_pass", int'(pass[0]), 0);

    // SETTLE=3 with a start re-pulse mid-sweep
    run_sweep(1, 32'h0, 50, n);
    chk("len_settle3", n, 129);
    chk("s3_pass", int'(pass[1]), 1);

    // Random fault patterns
    for (int k = 0; k < 6; k++) begin
      int i;
      i = int'($urandom_range(0, 1));
      m = (k % 2 == 0) ? $urandom : ($urandom & $urandom & $urandom);
      run_sweep(i, m, int'($urandom_range(2, 60)), n);
      chk($sformatf("rand_len%0d", i), n, len_of(i));
      chk($sformatf("rand_err%0d", i), int'(err[i]), $countones(m));
    end

    // Asynchronous reset mid-sweep at vector 12
    @(negedge clk);
    mask[0] = 32'h0000_0FFF;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while ({sel[0], a[0], b[0]} != 5'd12 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec12", int'({sel[0], a[0], b[0]}), 12);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vec", int'({sel[0], a[0], b[0]}), 0);
    chk("arst_busy", int'(busy[0]), 0);
    chk("arst_err", int'(err[0]), 0);
    chk("arst_fev", int'(fev[0]), 0);
    chk("arst_pass", int'(pass[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 32'h8000_0001, 0, n);
    chk("restart_len", n, 65);
    chk("restart_err", int'(err[0]), 2);
    chk("restart_fev", int'(fev[0]), 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
